// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
// Shared definitions for the push-button conditioning stage.
//   - Default cycle counts for a 100 MHz system clock.
//   - Encoding of the auto-repeat phase (waiting for first repeat vs. repeating).
//   - Small helper for sizing counters.
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

    // 10 ms debounce, 500 ms before the first repeat, 200 ms between repeats
    localparam int DEB_CYCLES_100MHZ    = 1_000_000;
    localparam int HOLD_CYCLES_100MHZ   = 50_000_000;
    localparam int REPEAT_CYCLES_100MHZ = 20_000_000;

    // INITIAL: counting towards the first repeat; REPEAT: counting between repeats
    typedef enum logic {
        PH_INITIAL = 1'b0,
        PH_REPEAT  = 1'b1
    } rep_phase_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One button slice: two-flop synchroniser, stable-count debounce filter and
// long-press auto-repeat pulse generator.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   i_btn   in   raw asynchronous button pin
//   o_level out  debounced clean level (registered)
//   o_rep   out  one-cycle auto-repeat pulse (registered)
// -----------------------------------------------------------------------------
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_100MHZ,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_100MHZ,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_100MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rep
);

    // Counters only ever reach (terminal - 1) before clearing, so $clog2 suffices.
    // The hold counter serves both phases, so it is sized for the larger one.
    localparam int DCNT_W = $clog2(DEB_CYCLES);
    localparam int HCNT_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));

    localparam logic [DCNT_W-1:0] DEB_LAST  = DCNT_W'(DEB_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [HCNT_W-1:0] REP_LAST  = HCNT_W'(REPEAT_CYCLES - 1);

    logic              r_s1;
    logic              r_s;
    logic              r_q;
    logic [DCNT_W-1:0] r_dcnt;
    logic [HCNT_W-1:0] r_hcnt;
    rep_phase_t        r_phase;
    logic              r_rep;

    // Bring the asynchronous pin into the clk domain before anything looks at it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s  <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s  <= r_s1;
        end
    end

    // Accept a new level only after it has disagreed with the clean level for
    // DEB_CYCLES consecutive edges; any agreement in between restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= 1'b0;
            r_dcnt <= '0;
        end else if (r_s == r_q) begin
            r_dcnt <= '0;
        end else if (r_dcnt == DEB_LAST) begin
            r_q    <= r_s;
            r_dcnt <= '0;
        end else begin
            r_dcnt <= r_dcnt + DCNT_W'(1);
        end
    end

    // Auto-repeat runs off the registered clean level, so the edge on which the
    // level falls still sees it high and can emit a pulse that is due then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt  <= '0;
            r_phase <= PH_INITIAL;
            r_rep   <= 1'b0;
        end else if (!r_q) begin
            r_hcnt  <= '0;
            r_phase <= PH_INITIAL;
            r_rep   <= 1'b0;
        end else if (r_phase == PH_INITIAL && r_hcnt == HOLD_LAST) begin
            r_hcnt  <= '0;
            r_phase <= PH_REPEAT;
            r_rep   <= 1'b1;
        end else if (r_phase == PH_REPEAT && r_hcnt == REP_LAST) begin
            r_hcnt  <= '0;
            r_rep   <= 1'b1;
        end else begin
            r_hcnt  <= r_hcnt + HCNT_W'(1);
            r_rep   <= 1'b0;
        end
    end

    assign o_level = r_q;
    assign o_rep   = r_rep;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions N_BTN raw push-button pins into clean debounced levels plus
// per-button auto-repeat pulses. Channels are independent copies of
// button_channel.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   btn_in     in   [N_BTN] raw asynchronous button pins, active-high
//   btn_level  out  [N_BTN] debounced clean levels (registered)
//   btn_rep    out  [N_BTN] one-cycle auto-repeat pulses (registered)
// -----------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN         = 5,
    parameter int DEB_CYCLES    = DEB_CYCLES_100MHZ,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_100MHZ,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_100MHZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rep
);

    // One self-contained slice per button; no interaction between channels.
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        button_channel #(
            .DEB_CYCLES    (DEB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (btn_in[gi]),
            .o_level (btn_level[gi]),
            .o_rep   (btn_rep[gi])
        );
    end

endmodule
